// File: rtl/bin_to_7seg_if.sv
// rtl/bin_to_7seg_if.sv - digit value/control inputs and segment drive outputs for one display digit
interface bin_to_7seg_if;
    logic [3:0] binary;
    logic       blank;
    logic       lamp_test;
    logic       dp_in;
    logic [6:0] seg;
    logic       dp;

    modport master (
        output binary, blank, lamp_test, dp_in,
        input  seg, dp
    );

    modport slave (
        input  binary, blank, lamp_test, dp_in,
        output seg, dp
    );
endinterface

// File: rtl/bin_to_7seg.sv
// rtl/bin_to_7seg.sv - registered binary to seven-segment decoder; BIN_TO_7SEG_HEX_EN enables A-F glyphs
module bin_to_7seg #(
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    bin_to_7seg_if.slave bus
);

    logic [6:0] glyph;
    logic [6:0] seg_logic;
    logic       dp_logic;
    logic [6:0] seg_q;
    logic       dp_q;

    // Glyphs are in lit-high form, bit 6 = a down to bit 0 = g.
    always_comb begin
        glyph = 7'b0000000;
        case (bus.binary)
            4'd0:    glyph = 7'b1111110;
            4'd1:    glyph = 7'b0110000;
            4'd2:    glyph = 7'b1101101;
            4'd3:    glyph = 7'b1111001;
            4'd4:    glyph = 7'b0110011;
            4'd5:    glyph = 7'b1011011;
            4'd6:    glyph = 7'b1011111;
            4'd7:    glyph = 7'b1110000;
            4'd8:    glyph = 7'b1111111;
            4'd9:    glyph = 7'b1111011;
`ifdef BIN_TO_7SEG_HEX_EN
            4'd10:   glyph = 7'b1110111;
            4'd11:   glyph = 7'b0011111;
            4'd12:   glyph = 7'b1001110;
            4'd13:   glyph = 7'b0111101;
            4'd14:   glyph = 7'b1001111;
            4'd15:   glyph = 7'b1000111;
`endif
            default: glyph = 7'b0000000;
        endcase
    end

    always_comb begin
        seg_logic = glyph;
        dp_logic  = bus.dp_in;
        if (bus.lamp_test) begin
            seg_logic = 7'b1111111;
            dp_logic  = 1'b1;
        end else if (bus.blank) begin
            seg_logic = 7'b0000000;
            dp_logic  = 1'b0;
        end
    end

    // Polarity is folded in before the register so the pins are driven straight from flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q <= {7{SEG_ACTIVE_LOW}};
            dp_q  <= SEG_ACTIVE_LOW;
        end else begin
            seg_q <= seg_logic ^ {7{SEG_ACTIVE_LOW}};
            dp_q  <= dp_logic ^ SEG_ACTIVE_LOW;
        end
    end

    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;

endmodule

// File: tb/tb_bin_to_7seg.sv
// tb/tb_bin_to_7seg.sv - self-checking bench for bin_to_7seg, both polarities side by side
module tb_bin_to_7seg;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [6:0] lit_table [16];

    bin_to_7seg_if bus_ch ();
    bin_to_7seg_if bus_ca ();

    bin_to_7seg #(.SEG_ACTIVE_LOW(1'b0)) dut_ch (.clk(clk), .rst(rst), .bus(bus_ch));
    bin_to_7seg #(.SEG_ACTIVE_LOW(1'b1)) dut_ca (.clk(clk), .rst(rst), .bus(bus_ca));

    always #5 clk = ~clk;

    // Expected pin values {seg, dp} for a sampled input set.
    function automatic logic [7:0] model(input logic r, input logic [3:0] b, input logic bl,
                                         input logic lt, input logic dpi, input logic low);
        logic [7:0] lit;
        if (r)       lit = 8'h00;
        else if (lt) lit = 8'hFF;
        else if (bl) lit = 8'h00;
        else         lit = {lit_table[b], dpi};
        return low ? ~lit : lit;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic r, input logic [3:0] b, input logic bl,
                        input logic lt, input logic dpi);
        @(negedge clk);
        rst = r;
        bus_ch.binary = b; bus_ch.blank = bl; bus_ch.lamp_test = lt; bus_ch.dp_in = dpi;
        bus_ca.binary = b; bus_ca.blank = bl; bus_ca.lamp_test = lt; bus_ca.dp_in = dpi;
        @(posedge clk);
        #1;
        chk({tag, "_ch"}, {bus_ch.seg, bus_ch.dp}, model(r, b, bl, lt, dpi, 1'b0));
        chk({tag, "_ca"}, {bus_ca.seg, bus_ca.dp}, model(r, b, bl, lt, dpi, 1'b1));
    endtask

    initial begin
        lit_table[0]  = 7'b1111110; lit_table[1]  = 7'b0110000;
        lit_table[2]  = 7'b1101101; lit_table[3]  = 7'b1111001;
        lit_table[4]  = 7'b0110011; lit_table[5]  = 7'b1011011;
        lit_table[6]  = 7'b1011111; lit_table[7]  = 7'b1110000;
        lit_table[8]  = 7'b1111111; lit_table[9]  = 7'b1111011;
`ifdef BIN_TO_7SEG_HEX_EN
        lit_table[10] = 7'b1110111; lit_table[11] = 7'b0011111;
        lit_table[12] = 7'b1001110; lit_table[13] = 7'b0111101;
        lit_table[14] = 7'b1001111; lit_table[15] = 7'b1000111;
`else
        for (int i = 10; i < 16; i++) lit_table[i] = 7'b0000000;
`endif
        bus_ch.binary = 4'h0; bus_ch.blank = 1'b0; bus_ch.lamp_test = 1'b0; bus_ch.dp_in = 1'b0;
        bus_ca.binary = 4'h0; bus_ca.blank = 1'b0; bus_ca.lamp_test = 1'b0; bus_ca.dp_in = 1'b0;

        // Reset with an 8 waiting, then the 8 appears one cycle after release.
        step("reset0", 1'b1, 4'h8, 1'b0, 1'b0, 1'b0);
        step("reset1", 1'b1, 4'h8, 1'b0, 1'b0, 1'b0);
        step("post_reset", 1'b0, 4'h8, 1'b0, 1'b0, 1'b0);
        chk("eight_lit", {bus_ch.seg, bus_ch.dp}, 8'b11111110);

        for (int v = 0; v < 16; v++) step($sformatf("sweep%0d", v), 1'b0, v[3:0], 1'b0, 1'b0, 1'b0);

        step("lamp_over_blank", 1'b0, 4'h3, 1'b1, 1'b1, 1'b0);
        chk("lamp_lit", {bus_ch.seg, bus_ch.dp}, 8'b11111111);
        step("blank", 1'b0, 4'h3, 1'b1, 1'b0, 1'b0);
        chk("blank_off", {bus_ch.seg, bus_ch.dp}, 8'b00000000);
        step("three_dp", 1'b0, 4'h3, 1'b0, 1'b0, 1'b1);
        chk("three_dp_lit", {bus_ch.seg, bus_ch.dp}, 8'b11110011);

        step("ca_zero", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        chk("ca_zero_pins", {bus_ca.seg, bus_ca.dp}, 8'b00000011);
        step("ca_one", 1'b0, 4'h1, 1'b0, 1'b0, 1'b0);
        chk("ca_one_pins", bus_ca.seg, 7'b1001111);

        // Reset mid-sweep, then resume.
        step("mid_a", 1'b0, 4'h5, 1'b0, 1'b0, 1'b1);
        step("mid_rst", 1'b1, 4'h6, 1'b0, 1'b1, 1'b1);
        step("mid_resume", 1'b0, 4'h7, 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] r;
            r = $urandom;
            step($sformatf("rand%0d", n), (r[7:0] < 8'd12), r[11:8], (r[15:12] == 4'h0),
                 (r[19:16] == 4'h0), r[20]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
